// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS EX/MEM stage: field widths, funct codes,
// ALUOp encodings, the multiplier FSM states and the EX/MEM register layout.
package mips_pkg;

  localparam int PC_W   = 8;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTL_W  = 3;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  localparam logic ALUOP_ADD   = 1'b0;
  localparam logic ALUOP_RTYPE = 1'b1;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  typedef struct packed {
    logic [CTL_W-1:0]  wb;
    logic [CTL_W-1:0]  m;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store;
    logic [REG_W-1:0]  wreg;
    logic [PC_W-1:0]   target;
    logic              valid;
  } bf2_t;

endpackage

// File: rtl/alu_bf2.sv
// Combinational ALU-control decode plus ALU for the execute stage. MULT is
// only flagged here; the iterative multiplier lives in the stage top.
module alu_bf2
  import mips_pkg::*;
(
  input  logic              alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              illegal,
  output logic              is_mult
);

  // decode ALUOp/funct and evaluate the selected operation
  always_comb begin
    result  = {DATA_W{1'b0}};
    illegal = 1'b0;
    is_mult = 1'b0;
    if (alu_op == ALUOP_ADD) begin
      result = op_a + op_b;
    end else begin
      case (funct)
        FUNCT_ADD:  result = op_a + op_b;
        FUNCT_SUB:  result = op_a - op_b;
        FUNCT_AND:  result = op_a & op_b;
        FUNCT_OR:   result = op_a | op_b;
        FUNCT_NOR:  result = ~(op_a | op_b);
        FUNCT_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        FUNCT_MULT: is_mult = 1'b1;
        default:    illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register (BF2), including a 32-step
// shift-add multiplier that back-pressures BF1 through busy_BF2.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk_BF2,
  input  logic              rstn_BF2,
  input  logic              valid_BF2_IN,
  input  logic [CTL_W-1:0]  WB_BF2_IN,
  input  logic [CTL_W-1:0]  M_BF2_IN,
  input  logic              RegDst_BF2_IN,
  input  logic              ALUOp_BF2_IN,
  input  logic              ALUSrc_BF2_IN,
  input  logic [PC_W-1:0]   nextInst_BF2_IN,
  input  logic [DATA_W-1:0] regData1_BF2_IN,
  input  logic [DATA_W-1:0] regData2_BF2_IN,
  input  logic [DATA_W-1:0] rdshfunct_BF2_IN,
  input  logic [REG_W-1:0]  rd_BF2_IN,
  input  logic [REG_W-1:0]  rt_BF2_IN,
  input  logic              flush_BF2,
  input  logic              stall_BF2,
  output logic [CTL_W-1:0]  WB_BF2,
  output logic [CTL_W-1:0]  M_BF2,
  output logic [DATA_W-1:0] aluResult_BF2,
  output logic              zero_BF2,
  output logic [DATA_W-1:0] storeData_BF2,
  output logic [REG_W-1:0]  writeReg_BF2,
  output logic [PC_W-1:0]   branchTarget_BF2,
  output logic              valid_BF2,
  output logic              busy_BF2
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  bf2_t              out_r, nxt_s;
  logic              zero_r;
  logic              capture_s;

  logic [DATA_W-1:0] op_b_s, alu_res_s, mul_step_s;
  logic [REG_W-1:0]  dest_s;
  logic [PC_W-1:0]   target_s;
  logic              illegal_s, is_mult_s;

  logic [DATA_W-1:0] mcand_r, mplier_r, prod_r, cap_store_r;
  logic [CTL_W-1:0]  cap_wb_r, cap_m_r;
  logic [REG_W-1:0]  cap_wreg_r;
  logic [PC_W-1:0]   cap_tgt_r;

  assign op_b_s     = ALUSrc_BF2_IN ? rdshfunct_BF2_IN : regData2_BF2_IN;
  assign dest_s     = RegDst_BF2_IN ? rd_BF2_IN : rt_BF2_IN;
  assign target_s   = nextInst_BF2_IN + rdshfunct_BF2_IN[PC_W-1:0];
  // final partial product folds in combinationally so completion needs no extra cycle
  assign mul_step_s = prod_r + (mplier_r[0] ? mcand_r : {DATA_W{1'b0}});

  alu_bf2 u_alu (
    .alu_op  (ALUOp_BF2_IN),
    .funct   (rdshfunct_BF2_IN[5:0]),
    .op_a    (regData1_BF2_IN),
    .op_b    (op_b_s),
    .result  (alu_res_s),
    .illegal (illegal_s),
    .is_mult (is_mult_s)
  );

  // next-state, counter and next EX/MEM register contents
  always_comb begin
    nxt_s       = '0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_BF2_IN && is_mult_s) begin
          capture_s   = 1'b1;
          state_nxt_s = MUL;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (valid_BF2_IN) begin
          nxt_s.wb     = illegal_s ? {CTL_W{1'b0}} : WB_BF2_IN;
          nxt_s.m      = illegal_s ? {CTL_W{1'b0}} : M_BF2_IN;
          nxt_s.result = alu_res_s;
          nxt_s.store  = regData2_BF2_IN;
          nxt_s.wreg   = dest_s;
          nxt_s.target = target_s;
          nxt_s.valid  = 1'b1;
        end else begin
          nxt_s = '0;
        end
      end
      MUL: begin
        if (cnt_r == CNT_LAST) begin
          nxt_s.wb     = cap_wb_r;
          nxt_s.m      = cap_m_r;
          nxt_s.result = mul_step_s;
          nxt_s.store  = cap_store_r;
          nxt_s.wreg   = cap_wreg_r;
          nxt_s.target = cap_tgt_r;
          nxt_s.valid  = 1'b1;
          state_nxt_s  = IDLE;
          cnt_nxt_s    = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM, counter and EX/MEM output register; flush beats stall
  always_ff @(posedge clk_BF2 or negedge rstn_BF2) begin
    if (!rstn_BF2) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      out_r   <= '0;
      zero_r  <= 1'b0;
    end else if (flush_BF2) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      out_r   <= '0;
      zero_r  <= 1'b1;
    end else if (!stall_BF2) begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      out_r   <= nxt_s;
      zero_r  <= (nxt_s.result == {DATA_W{1'b0}});
    end
  end

  // multiplier operands, running product and captured instruction fields
  always_ff @(posedge clk_BF2 or negedge rstn_BF2) begin
    if (!rstn_BF2) begin
      mcand_r     <= {DATA_W{1'b0}};
      mplier_r    <= {DATA_W{1'b0}};
      prod_r      <= {DATA_W{1'b0}};
      cap_store_r <= {DATA_W{1'b0}};
      cap_wb_r    <= {CTL_W{1'b0}};
      cap_m_r     <= {CTL_W{1'b0}};
      cap_wreg_r  <= {REG_W{1'b0}};
      cap_tgt_r   <= {PC_W{1'b0}};
    end else if (!flush_BF2 && !stall_BF2) begin
      if (capture_s) begin
        mcand_r     <= regData1_BF2_IN;
        mplier_r    <= op_b_s;
        prod_r      <= {DATA_W{1'b0}};
        cap_store_r <= regData2_BF2_IN;
        cap_wb_r    <= WB_BF2_IN;
        cap_m_r     <= M_BF2_IN;
        cap_wreg_r  <= dest_s;
        cap_tgt_r   <= target_s;
      end else if (state_r == MUL) begin
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        prod_r   <= mul_step_s;
      end
    end
  end

  assign WB_BF2           = out_r.wb;
  assign M_BF2            = out_r.m;
  assign aluResult_BF2    = out_r.result;
  assign zero_BF2         = zero_r;
  assign storeData_BF2    = out_r.store;
  assign writeReg_BF2     = out_r.wreg;
  assign branchTarget_BF2 = out_r.target;
  assign valid_BF2        = out_r.valid;
  assign busy_BF2         = (state_r == MUL);

endmodule
